// File: rtl/piezo_pkg.sv
// Shared state and grant encodings for the piezo sound arbiter and its tone generator.
package piezo_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [2:0] G_NONE    = 3'd0;
  localparam logic [2:0] G_TICK    = 3'd1;
  localparam logic [2:0] G_WARN    = 3'd2;
  localparam logic [2:0] G_DEFUSED = 3'd3;
  localparam logic [2:0] G_BOMB    = 3'd4;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator: half-period chosen by the current owner, restartable so that
// every new owner or state entry begins on a full high half-period.
module piezo_tone_gen
  import piezo_pkg::*;
#(
  parameter int HALF_TICK = 318,
  parameter int HALF_WARN = 212,
  parameter int HALF_DEF  = 159,
  parameter int HALF_BOMB = 636
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       restart,
  input  logic [2:0] sel,
  output logic       tone
);

  localparam int CNT_W = $clog2(max4(HALF_TICK, HALF_WARN, HALF_DEF, HALF_BOMB) + 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] last_s;
  logic             tone_r;

  // Last count value of the half-period for the selected owner.
  always_comb begin
    case (sel)
      G_TICK:    last_s = CNT_W'(HALF_TICK - 1);
      G_WARN:    last_s = CNT_W'(HALF_WARN - 1);
      G_DEFUSED: last_s = CNT_W'(HALF_DEF - 1);
      G_BOMB:    last_s = CNT_W'(HALF_BOMB - 1);
      default:   last_s = {CNT_W{1'b0}};
    endcase
  end

  // Half-period counter and tone toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      tone_r <= 1'b0;
    end else if (restart) begin
      cnt_r  <= {CNT_W{1'b0}};
      tone_r <= 1'b1;
    end else if (en && (sel != G_NONE)) begin
      // >= keeps a stale count from running past a shorter half-period
      if (cnt_r >= last_s) begin
        cnt_r  <= {CNT_W{1'b0}};
        tone_r <= ~tone_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
    end
  end

  assign tone = tone_r;

endmodule

// File: rtl/piezo_sound_arbiter.sv
// Arbitrates tick/warn beeps and bomb/defused holds onto one piezo, with fixed priority,
// post-beep silence and a combinational mute on the drive.
module piezo_sound_arbiter
  import piezo_pkg::*;
#(
  parameter int HALF_TICK = 318,
  parameter int HALF_WARN = 212,
  parameter int HALF_DEF  = 159,
  parameter int HALF_BOMB = 636,
  parameter int DUR_BEEP  = 20000,
  parameter int GAP       = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bomb,
  input  logic       defused,
  input  logic       warn_req,
  input  logic       tick_req,
  input  logic       mute,
  output logic       piezoout,
  output logic [2:0] grant,
  output logic       busy
);

  localparam int DUR_W = $clog2(DUR_BEEP);
  localparam int GAP_W = $clog2(GAP);
  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(DUR_BEEP - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  state_t           state_r;
  logic [2:0]       grant_r;
  logic             busy_r;
  logic             run_r;
  logic             tick_pend_r;
  logic             warn_pend_r;
  logic [DUR_W-1:0] dur_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;

  logic [2:0]       hold_grant_s;
  logic             want_warn_s;
  logic             want_tick_s;
  logic             restart_s;
  logic             tone_s;

  // Reset release is taken through one flop so the FSM first samples on the second edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Request winners and the tone restart strobe, aligned with the FSM's granting edge.
  always_comb begin
    hold_grant_s = bomb ? G_BOMB : G_DEFUSED;
    want_warn_s  = warn_pend_r | warn_req;
    want_tick_s  = tick_pend_r | tick_req;
    if (!run_r) begin
      restart_s = 1'b0;
    end else if (bomb || defused) begin
      restart_s = (state_r != S_HOLD) || (grant_r != hold_grant_s);
    end else if (state_r == S_IDLE) begin
      restart_s = want_warn_s | want_tick_s;
    end else begin
      restart_s = 1'b0;
    end
  end

  // Arbitration FSM with pending flags, beep duration and gap counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      grant_r     <= G_NONE;
      busy_r      <= 1'b0;
      tick_pend_r <= 1'b0;
      warn_pend_r <= 1'b0;
      dur_cnt_r   <= {DUR_W{1'b0}};
      gap_cnt_r   <= {GAP_W{1'b0}};
    end else if (run_r) begin
      if (bomb || defused) begin
        state_r     <= S_HOLD;
        grant_r     <= hold_grant_s;
        busy_r      <= 1'b1;
        tick_pend_r <= 1'b0;
        warn_pend_r <= 1'b0;
        dur_cnt_r   <= {DUR_W{1'b0}};
        gap_cnt_r   <= {GAP_W{1'b0}};
      end else begin
        case (state_r)
          S_IDLE: begin
            if (want_warn_s) begin
              state_r     <= S_PLAY;
              grant_r     <= G_WARN;
              busy_r      <= 1'b1;
              warn_pend_r <= 1'b0;
              tick_pend_r <= want_tick_s;
              dur_cnt_r   <= {DUR_W{1'b0}};
            end else if (want_tick_s) begin
              state_r     <= S_PLAY;
              grant_r     <= G_TICK;
              busy_r      <= 1'b1;
              tick_pend_r <= 1'b0;
              dur_cnt_r   <= {DUR_W{1'b0}};
            end
          end
          S_PLAY: begin
            warn_pend_r <= warn_pend_r | warn_req;
            tick_pend_r <= tick_pend_r | tick_req;
            if (dur_cnt_r == DUR_LAST) begin
              state_r   <= S_GAP;
              grant_r   <= G_NONE;
              dur_cnt_r <= {DUR_W{1'b0}};
              gap_cnt_r <= {GAP_W{1'b0}};
            end else begin
              dur_cnt_r <= dur_cnt_r + DUR_W'(1'b1);
            end
          end
          S_GAP: begin
            warn_pend_r <= warn_pend_r | warn_req;
            tick_pend_r <= tick_pend_r | tick_req;
            if (gap_cnt_r == GAP_LAST) begin
              state_r   <= S_IDLE;
              busy_r    <= 1'b0;
              gap_cnt_r <= {GAP_W{1'b0}};
            end else begin
              gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
            end
          end
          S_HOLD: begin
            // Requests seen during HOLD are dropped; pending flags are already clear.
            state_r <= S_IDLE;
            grant_r <= G_NONE;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r <= S_IDLE;
            grant_r <= G_NONE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  piezo_tone_gen #(
    .HALF_TICK(HALF_TICK),
    .HALF_WARN(HALF_WARN),
    .HALF_DEF (HALF_DEF),
    .HALF_BOMB(HALF_BOMB)
  ) u_tone (
    .clk    (clk),
    .rst    (rst),
    .en     (run_r),
    .restart(restart_s),
    .sel    (grant_r),
    .tone   (tone_s)
  );

  assign piezoout = tone_s & ((state_r == S_PLAY) || (state_r == S_HOLD)) & ~mute;
  assign grant    = grant_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_piezo_sound_arbiter.sv
// Randomized scoreboard bench: a cycle-level behavioural model predicts grant/busy/piezoout
// each cycle and a separate monitor compares them against the DUT on the falling edge.
module tb_piezo_sound_arbiter;

  localparam int HT = 4, HW = 3, HD = 2, HB = 5, DUR = 20, GP = 5;
  localparam int M_IDLE = 0, M_PLAY = 1, M_GAP = 2, M_HOLD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bomb = 1'b0, defused = 1'b0, warn_req = 1'b0, tick_req = 1'b0, mute = 1'b0;
  logic       piezoout;
  logic [2:0] grant;
  logic       busy;

  piezo_sound_arbiter #(
    .HALF_TICK(HT), .HALF_WARN(HW), .HALF_DEF(HD), .HALF_BOMB(HB),
    .DUR_BEEP(DUR), .GAP(GP)
  ) dut (
    .clk(clk), .rst(rst), .bomb(bomb), .defused(defused),
    .warn_req(warn_req), .tick_req(tick_req), .mute(mute),
    .piezoout(piezoout), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] grant;
    logic       busy;
    logic       piezo;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: mode, owner, cycles left in mode, cycles since tone start.
  int m_mode, m_owner, m_rem, m_age, m_runwait;
  bit m_pw, m_pt;

  function automatic int half_of(input int owner);
    case (owner)
      1: return HT;
      2: return HW;
      3: return HD;
      4: return HB;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_owner = 0; m_rem = 0; m_age = 0;
    m_pw = 1'b0; m_pt = 1'b0; m_runwait = 1;
  endtask

  // One clock edge of the spec's behaviour, using the inputs held during the past cycle.
  task automatic model_edge();
    int nown;
    if (m_runwait > 0) begin
      m_runwait--;
      return;
    end
    if (bomb || defused) begin
      nown = bomb ? 4 : 3;
      if (m_mode == M_HOLD && m_owner == nown) m_age++;
      else m_age = 0;
      m_mode = M_HOLD; m_owner = nown; m_pw = 1'b0; m_pt = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (m_pw || warn_req) begin
            m_mode = M_PLAY; m_owner = 2; m_rem = DUR; m_age = 0;
            m_pw = 1'b0; m_pt = m_pt || tick_req;
          end else if (m_pt || tick_req) begin
            m_mode = M_PLAY; m_owner = 1; m_rem = DUR; m_age = 0;
            m_pt = 1'b0;
          end
        end
        M_PLAY: begin
          m_pw = m_pw || warn_req; m_pt = m_pt || tick_req;
          m_rem--; m_age++;
          if (m_rem == 0) begin m_mode = M_GAP; m_rem = GP; m_owner = 0; end
        end
        M_GAP: begin
          m_pw = m_pw || warn_req; m_pt = m_pt || tick_req;
          m_rem--;
          if (m_rem == 0) m_mode = M_IDLE;
        end
        default: begin
          m_mode = M_IDLE; m_owner = 0;
        end
      endcase
    end
  endtask

  task automatic push_expect();
    exp_t e;
    bit   sounding, tone_hi;
    sounding = (m_mode == M_PLAY) || (m_mode == M_HOLD);
    tone_hi  = ((m_age / half_of(m_owner)) % 2) == 0;
    e.grant  = 3'(m_owner);
    e.busy   = (m_mode != M_IDLE);
    e.piezo  = sounding && tone_hi && !mute;
    sb_q.push_back(e);
  endtask

  // One stimulus cycle: advance the model over the edge, then drive the next inputs.
  task automatic cycle(input bit r, input bit b, input bit d, input bit w, input bit t, input bit m);
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
    rst = r; bomb = b; defused = d; warn_req = w; tick_req = t; mute = m;
    if (!rst) model_reset();
    push_expect();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares the DUT against the oldest prediction each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checks++;
        if (grant !== mon_e.grant) begin
          errors++;
          $display("FAIL grant t=%0t got=%0d want=%0d", $time, grant, mon_e.grant);
        end
        checks++;
        if (busy !== mon_e.busy) begin
          errors++;
          $display("FAIL busy t=%0t got=%0b want=%0b", $time, busy, mon_e.busy);
        end
        checks++;
        if (piezoout !== mon_e.piezo) begin
          errors++;
          $display("FAIL piezoout t=%0t got=%0b want=%0b", $time, piezoout, mon_e.piezo);
        end
      end
    end
  end

  bit s_b, s_d, s_m;
  int rst_hold;

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);
    // single tick beep through PLAY, GAP and back to IDLE
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(40);
    // simultaneous warn and tick: warn first, tick after the gap
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(60);
    // bomb aborts a tick beep
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, (i == 3), 1'b0);
    idle(20);
    // bomb and defused together, then defused alone
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    // mute window inside a tick beep
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (i >= 4 && i < 12));
    // reset mid-PLAY with a tick pending: must not replay
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(40);
    // request immediately after reset release
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(40);

    s_b = 1'b0; s_d = 1'b0; s_m = 1'b0; rst_hold = 0;
    for (int i = 0; i < 6000; i++) begin
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(1999, 0) == 0) rst_hold = $urandom_range(3, 1);
      if (s_b) s_b = ($urandom_range(24, 0) != 0);
      else s_b = ($urandom_range(599, 0) == 0);
      if (s_d) s_d = ($urandom_range(19, 0) != 0);
      else s_d = ($urandom_range(449, 0) == 0);
      if ($urandom_range(39, 0) == 0) s_m = ~s_m;
      cycle((rst_hold == 0), s_b, s_d, ($urandom_range(49, 0) == 0),
            ($urandom_range(34, 0) == 0), s_m);
    end

    @(negedge clk);
    @(negedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
